// File: rtl/div_unit_pkg.sv
// Shared constants for the RV64M divide unit: one-hot op bit positions
// and the divider FSM state encoding.
package div_unit_pkg;

  localparam int DivopDiv   = 0;
  localparam int DivopDivu  = 1;
  localparam int DivopRem   = 2;
  localparam int DivopRemu  = 3;
  localparam int DivopDivw  = 4;
  localparam int DivopDivuw = 5;
  localparam int DivopRemw  = 6;
  localparam int DivopRemuw = 7;
  localparam int DivopWidth = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between EX issue logic and the divider.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DivopWidth-1:0] div_op;
  logic [XLEN-1:0]       src1;
  logic [XLEN-1:0]       src2;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       result;

  modport master (
    output flush, in_valid, div_op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, div_op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the eight RV64M divide ops;
// divide-by-zero and signed overflow complete straight from IDLE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  div_unit_if.slave bus
);

  localparam int HalfW = XLEN / 2;
  localparam int CntW  = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]  MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HalfW-1:0] MinHalf = {1'b1, {(HalfW-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            signed_op_q, signed_op_d;
  logic            word_op_q, word_op_d;
  logic            rem_op_q, rem_op_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v);
    return {{HalfW{v[HalfW-1]}}, v[HalfW-1:0]};
  endfunction

  logic            is_signed, is_word, is_rem, accept;
  logic            div_zero, overflow, special, a_neg, b_neg;
  logic [XLEN-1:0] a_eff, b_eff, a_abs, b_abs, special_sel, special_res;

  assign is_signed = bus.div_op[DivopDiv] | bus.div_op[DivopRem] |
                     bus.div_op[DivopDivw] | bus.div_op[DivopRemw];
  assign is_word   = bus.div_op[DivopDivw] | bus.div_op[DivopDivuw] |
                     bus.div_op[DivopRemw] | bus.div_op[DivopRemuw];
  assign is_rem    = bus.div_op[DivopRem] | bus.div_op[DivopRemu] |
                     bus.div_op[DivopRemw] | bus.div_op[DivopRemuw];
  assign accept    = bus.in_valid & (state_q == DIV_IDLE) & ~bus.flush;

  assign a_eff = is_word ? {{HalfW{is_signed & bus.src1[HalfW-1]}}, bus.src1[HalfW-1:0]} : bus.src1;
  assign b_eff = is_word ? {{HalfW{is_signed & bus.src2[HalfW-1]}}, bus.src2[HalfW-1:0]} : bus.src2;

  // Overflow is judged at the op's own width, before any extension.
  assign div_zero = (b_eff == '0);
  assign overflow = is_signed & (is_word ?
                    (bus.src1[HalfW-1:0] == MinHalf && bus.src2[HalfW-1:0] == '1) :
                    (bus.src1 == MinFull && bus.src2 == '1));
  assign special  = div_zero | overflow;

  assign a_neg = is_signed & a_eff[XLEN-1];
  assign b_neg = is_signed & b_eff[XLEN-1];
  assign a_abs = a_neg ? -a_eff : a_eff;
  assign b_abs = b_neg ? -b_eff : b_eff;

  assign special_sel = is_rem ? (div_zero ? a_eff : '0) : (div_zero ? '1 : a_eff);
  assign special_res = is_word ? word_ext(special_sel) : special_sel;

  logic [XLEN+1:0] rem_sh, diff;
  logic            diff_neg;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_sel, fix_res;

  assign rem_sh   = {rem_q, quot_q[XLEN-1]};
  assign diff     = rem_sh - {2'b00, dvsr_q};
  assign diff_neg = diff[XLEN+1];

  assign quot_fix = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign fix_sel  = rem_op_q ? rem_fix : quot_fix;
  assign fix_res  = word_op_q ? word_ext(fix_sel) : fix_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == CntW'(1)) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: if (bus.out_ready) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (bus.flush) state_d = DIV_IDLE;
  end

  always_comb begin
    bus.in_ready  = rst_n && (state_q == DIV_IDLE);
    bus.out_valid = (state_q == DIV_DONE);
    bus.result    = result_q;
  end

  // Word ops park |dividend| in the upper half so 32 shifts suffice.
  always_comb begin
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    signed_op_d = signed_op_q;
    word_op_d   = word_op_q;
    rem_op_d    = rem_op_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    unique case (state_q)
      DIV_IDLE: if (accept) begin
        signed_op_d = is_signed;
        word_op_d   = is_word;
        rem_op_d    = is_rem;
        neg_quot_d  = a_neg ^ b_neg;
        neg_rem_d   = a_neg;
        quot_d      = is_word ? {a_abs[HalfW-1:0], {HalfW{1'b0}}} : a_abs;
        rem_d       = '0;
        dvsr_d      = b_abs;
        cnt_d       = is_word ? CntW'(HalfW) : CntW'(XLEN);
        if (special) result_d = special_res;
      end
      DIV_CALC: begin
        rem_d  = diff_neg ? rem_sh[XLEN:0] : diff[XLEN:0];
        quot_d = {quot_q[XLEN-2:0], ~diff_neg};
        cnt_d  = cnt_q - CntW'(1);
      end
      DIV_FIX:  result_d = fix_res;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quot_q      <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      signed_op_q <= 1'b0;
      word_op_q   <= 1'b0;
      rem_op_q    <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      signed_op_q <= signed_op_d;
      word_op_q   <= word_op_d;
      rem_op_q    <= rem_op_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RISC-V corner cases plus
// randomized ops compared against a plain-arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN = 64;

  localparam logic [7:0] OP_DIV   = 8'h01 << DivopDiv;
  localparam logic [7:0] OP_DIVU  = 8'h01 << DivopDivu;
  localparam logic [7:0] OP_REM   = 8'h01 << DivopRem;
  localparam logic [7:0] OP_DIVUW = 8'h01 << DivopDivuw;
  localparam logic [7:0] OP_REMW  = 8'h01 << DivopRemw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] val;
    int          due;
  } exp_t;

  exp_t expq[$];
  bit   seen_valid = 1'b0;

  div_unit_if #(.XLEN(XLEN)) dif ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%016h expected 0x%016h", name, cyc, act, exp);
    end
  endtask

  // Architectural RISC-V divide semantics, including the two special cases.
  function automatic void refModel(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] res, output int lat);
    bit sgn, word, rem;
    int sa, sb;
    int unsigned ua, ub;
    longint la, lb;
    longint unsigned lua, lub;
    logic [31:0] r32;
    sgn  = op[DivopDiv] | op[DivopRem] | op[DivopDivw] | op[DivopRemw];
    word = op[DivopDivw] | op[DivopDivuw] | op[DivopRemw] | op[DivopRemuw];
    rem  = op[DivopRem] | op[DivopRemu] | op[DivopRemw] | op[DivopRemuw];
    if (word) begin
      ua = a[31:0];
      ub = b[31:0];
      sa = $signed(a[31:0]);
      sb = $signed(b[31:0]);
      if (ub == 0) begin
        r32 = rem ? ua : 32'hFFFF_FFFF;
        lat = 1;
      end else if (sgn && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
        r32 = rem ? 32'd0 : ua;
        lat = 1;
      end else begin
        lat = 34;
        if (sgn) r32 = rem ? sa % sb : sa / sb;
        else     r32 = rem ? ua % ub : ua / ub;
      end
      res = {{32{r32[31]}}, r32};
    end else begin
      lua = a;
      lub = b;
      la  = $signed(a);
      lb  = $signed(b);
      if (lub == 0) begin
        res = rem ? lua : 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 1;
      end else if (sgn && lua == 64'h8000_0000_0000_0000 && lb == -64'sd1) begin
        res = rem ? 64'd0 : lua;
        lat = 1;
      end else begin
        lat = 66;
        if (sgn) res = rem ? la % lb : la / lb;
        else     res = rem ? lua % lub : lua / lub;
      end
    end
  endfunction

  // Output checker: every cycle with a result presented, plus busy in_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("in_ready_in_reset", 64'(dif.in_ready), 64'd0);
    end else begin
      if (expq.size() != 0) checkOutput("busy_in_ready", 64'(dif.in_ready), 64'd0);
      if (dif.out_valid) begin
        if (expq.size() == 0) begin
          checkOutput("spurious_valid", 64'(dif.out_valid), 64'd0);
        end else begin
          if (!seen_valid) begin
            checkOutput("latency", 64'(cyc), 64'(expq[0].due));
            seen_valid = 1'b1;
          end
          checkOutput("result", dif.result, expq[0].val);
          if (dif.out_ready) begin
            void'(expq.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                               input bit use_lit, input logic [63:0] lit, output int t_acc);
    logic [63:0] exp;
    int lat;
    int waited;
    refModel(op, a, b, exp, lat);
    if (use_lit) checkOutput("model_pin", exp, lit);
    dif.div_op   = op;
    dif.src1     = a;
    dif.src2     = b;
    dif.in_valid = 1'b1;
    waited = 0;
    while (!dif.in_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (!dif.in_ready) begin
      checkOutput("accept_timeout", 64'(dif.in_ready), 64'd1);
      dif.in_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    tick();
    expq.push_back('{val: exp, due: t_acc + lat});
    dif.in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int waited;
    waited = 0;
    while (!dif.out_valid && waited < 300) begin
      tick();
      waited++;
    end
    if (!dif.out_valid) begin
      checkOutput("valid_timeout", 64'(dif.out_valid), 64'd1);
      expq.delete();
      seen_valid = 1'b0;
      return;
    end
    repeat (hold) tick();
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  task automatic runOp(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit use_lit, input logic [63:0] lit, input int hold);
    int t;
    applyStimulus(op, a, b, use_lit, lit, t);
    if (t >= 0) collect(hold);
  endtask

  // Kill a DIV ten cycles in, then a DIVU 9/3 must be taken two cycles later.
  task automatic killCase(input bit use_reset);
    int t0, t1;
    applyStimulus(OP_DIV, 64'd1000, 64'd3, 1'b0, 64'd0, t0);
    repeat (9) tick();
    if (use_reset) rst_n = 1'b0;
    else           dif.flush = 1'b1;
    tick();
    rst_n     = 1'b1;
    dif.flush = 1'b0;
    expq.delete();
    seen_valid = 1'b0;
    tick();
    applyStimulus(OP_DIVU, 64'd9, 64'd3, 1'b1, 64'd3, t1);
    checkOutput(use_reset ? "reset_reaccept_cycle" : "flush_reaccept_cycle", 64'(t1), 64'(t0 + 12));
    collect(0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int t;
    logic [7:0] op;
    logic [63:0] a, b;
    dif.flush     = 1'b0;
    dif.in_valid  = 1'b0;
    dif.div_op    = '0;
    dif.src1      = '0;
    dif.src2      = '0;
    dif.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_out_valid", 64'(dif.out_valid), 64'd0);
    checkOutput("reset_result", dif.result, 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_in_ready", 64'(dif.in_ready), 64'd1);

    runOp(OP_DIV,   64'd100, 64'd7, 1'b1, 64'd14, 0);
    runOp(OP_REM,   64'd100, 64'd7, 1'b1, 64'd2, 1);
    runOp(OP_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    runOp(OP_DIVUW, 64'h0000_0001_FFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    runOp(OP_DIVU,  64'd12345, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    runOp(OP_REM,   -64'd5, 64'd0, 1'b1, -64'd5, 0);
    runOp(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 0);
    runOp(OP_REMW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 0);

    runOp(OP_DIV, 64'd100, 64'd7, 1'b1, 64'd14, 10);
    checkOutput("in_ready_after_release", 64'(dif.in_ready), 64'd1);

    killCase(1'b0);
    killCase(1'b1);

    applyStimulus(OP_DIVU, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, t);
    checkOutput("special_valid_next", 64'(dif.out_valid), 64'd1);
    tick();
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    expq.delete();
    seen_valid = 1'b0;
    checkOutput("flush_done_valid", 64'(dif.out_valid), 64'd0);
    checkOutput("flush_done_in_ready", 64'(dif.in_ready), 64'd1);

    for (int i = 0; i < 40; i++) begin
      op = 8'h01 << $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0: begin a = rnd64(); b = rnd64(); end
        1: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 50));
          if ($urandom_range(0, 1) != 0) a = -a;
          if ($urandom_range(0, 1) != 0) b = -b;
        end
        2: begin a = rnd64(); b = ($urandom_range(0, 1) != 0) ? 64'd0 : {$urandom, 32'h0}; end
        3: begin
          a = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : {$urandom, 32'h8000_0000};
          b = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, 32'hFFFF_FFFF};
        end
        4: begin a = {$urandom, $urandom}; b = {32'h0, $urandom}; end
        default: begin a = rnd64(); b = 64'($urandom_range(1, 255)); end
      endcase
      runOp(op, a, b, 1'b0, 64'd0, $urandom_range(0, 3));
    end

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
